// File: rtl/bubble_flash_loader_pkg.sv
// Shared definitions for the bubble buffer flash loader: FSM encoding, flash
// opcode and buffer geometry that the out sequencer's address ranges rely on.
package bubble_flash_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_t;

    localparam logic [7:0] READ_OPCODE = 8'h03;

    localparam int BOOT_WORDS_DEFAULT = 1920;
    localparam int PAGE_WORDS_DEFAULT = 512;

    localparam int BUF_ADDR_W = 11;
    localparam int BUF_WORD_W = 2;

    // Words leave a flash byte most-significant pair first.
    function automatic logic [BUF_WORD_W-1:0] word_of_byte(input logic [7:0] b,
                                                           input logic [1:0] k);
        logic [BUF_WORD_W-1:0] w;
        case (k)
            2'd0:    w = b[7:6];
            2'd1:    w = b[5:4];
            2'd2:    w = b[3:2];
            default: w = b[1:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bubble_flash_loader_spi_read_shifter.sv
// SPI mode-0 read engine: shifts a 32-bit command out, then bytes in.
// byte_valid/cmd_done are one-cycle strobes with no ready; the consumer holds stall high to pause SCK low.
module spi_read_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] cmd_word,
    input  logic        stall,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        cmd_done,
    output logic        byte_valid,
    output logic [7:0]  rx_byte
);
    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic          armed;
    logic          running;
    logic          rx_mode;
    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [31:0]   tx_sr;
    logic [7:0]    rx_sr;
    logic          advance;
    logic          rise_edge;
    logic          period_end;
    logic          last_bit;

    assign advance    = running && !stall && !clear;
    assign rise_edge  = advance && (div_cnt == DW'(HALF - 1));
    assign period_end = advance && (div_cnt == DW'(CLK_DIV - 1));
    assign last_bit   = (bit_cnt == 6'd1);
    assign cmd_done   = period_end && !rx_mode && last_bit;
    assign byte_valid = period_end && rx_mode && last_bit;
    assign rx_byte    = rx_sr;
    assign sck        = running && !clear && (div_cnt >= DW'(HALF));
    assign mosi       = tx_sr[31];

    // The armed cycle gives one SCK-low cycle with CS already asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed   <= 1'b0;
            running <= 1'b0;
            rx_mode <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else if (load) begin
            armed   <= 1'b1;
            running <= 1'b0;
            rx_mode <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= 6'd32;
            tx_sr   <= cmd_word;
        end else if (clear) begin
            armed   <= 1'b0;
            running <= 1'b0;
            rx_mode <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
        end else begin
            if (armed) begin
                armed   <= 1'b0;
                running <= 1'b1;
            end
            if (advance) begin
                div_cnt <= period_end ? '0 : div_cnt + 1'b1;
                if (rise_edge) rx_sr <= {rx_sr[6:0], miso};
                if (period_end) begin
                    tx_sr <= {tx_sr[30:0], 1'b0};
                    if (last_bit) begin
                        rx_mode <= 1'b1;
                        bit_cnt <= 6'd8;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bubble_flash_loader.sv
// Loads the bubble output buffer from SPI flash on a bootloader or page request,
// four 2-bit words per flash byte, writing from buffer address 0 upward.
module bubble_flash_loader
    import bubble_flash_loader_pkg::*;
#(
    parameter int          CLK_DIV    = 4,
    parameter logic [23:0] BOOT_BASE  = 24'h000000,
    parameter logic [23:0] PAGE_BASE  = 24'h000200,
    parameter int          BOOT_WORDS = BOOT_WORDS_DEFAULT,
    parameter int          PAGE_WORDS = PAGE_WORDS_DEFAULT
) (
    input  logic                  master_clock,
    input  logic                  reset,
    input  logic                  load_bootloader,
    input  logic                  load_page,
    input  logic [11:0]           page_number,
    output logic                  spi_cs_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic [BUF_ADDR_W-1:0] bubble_buffer_write_address,
    output logic [BUF_WORD_W-1:0] bubble_buffer_write_data_input,
    output logic                  bubble_buffer_write_enable,
    output logic                  bubble_buffer_write_clock,
    output logic                  loader_busy,
    output logic                  loader_done,
    output logic [2:0]            loader_state
);
    loader_state_t         state, next_state;
    logic [1:0]            boot_sync, page_sync;
    logic                  boot_prev, page_prev;
    logic                  boot_fall, page_fall, accept;
    logic                  sel_boot, req_level;
    logic [BUF_ADDR_W-1:0] word_count, word_total;
    logic [7:0]            byte_reg;
    logic [1:0]            word_k, wr_phase;
    logic                  word_done, last_word;
    logic [23:0]           flash_addr;
    logic                  sh_load, sh_clear, sh_stall;
    logic                  cmd_done, byte_valid;
    logic [7:0]            rx_byte;

    assign boot_fall  = boot_prev && !boot_sync[1];
    assign page_fall  = page_prev && !page_sync[1];
    assign accept     = (state == ST_IDLE) && (boot_fall || page_fall);
    assign req_level  = sel_boot ? boot_sync[1] : page_sync[1];
    assign flash_addr = boot_fall ? BOOT_BASE : PAGE_BASE + {5'b0, page_number, 7'b0};
    assign word_done  = (state == ST_WRITE) && (wr_phase == 2'd2);
    assign last_word  = (word_count == word_total - 1'b1);

    spi_read_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk        (master_clock),
        .reset      (reset),
        .clear      (sh_clear),
        .load       (sh_load),
        .cmd_word   ({READ_OPCODE, flash_addr}),
        .stall      (sh_stall),
        .miso       (spi_miso),
        .sck        (spi_sck),
        .mosi       (spi_mosi),
        .cmd_done   (cmd_done),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte)
    );

    always_ff @(posedge master_clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Releasing the accepted request before DONE aborts from any active state.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_CMD;
            ST_CMD: begin
                if (req_level)     next_state = ST_IDLE;
                else if (cmd_done) next_state = ST_DATA;
            end
            ST_DATA: begin
                if (req_level)       next_state = ST_IDLE;
                else if (byte_valid) next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (req_level)                      next_state = ST_IDLE;
                else if (word_done && last_word)    next_state = ST_DONE;
                else if (word_done && word_k == 2'd3) next_state = ST_DATA;
            end
            ST_DONE:  if (req_level) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        spi_cs_n                   = 1'b1;
        loader_busy                = 1'b0;
        loader_done                = 1'b0;
        bubble_buffer_write_enable = 1'b1;
        bubble_buffer_write_clock  = 1'b0;
        sh_stall                   = 1'b0;
        sh_clear                   = 1'b0;
        sh_load                    = 1'b0;
        case (state)
            ST_IDLE: begin
                sh_clear = 1'b1;
                sh_load  = accept;
            end
            ST_CMD, ST_DATA: begin
                spi_cs_n    = 1'b0;
                loader_busy = 1'b1;
            end
            ST_WRITE: begin
                spi_cs_n                   = 1'b0;
                loader_busy                = 1'b1;
                sh_stall                   = 1'b1;
                bubble_buffer_write_enable = (wr_phase == 2'd2);
                bubble_buffer_write_clock  = (wr_phase == 2'd1);
            end
            ST_DONE: begin
                loader_done = 1'b1;
                sh_clear    = 1'b1;
            end
            default: sh_clear = 1'b1;
        endcase
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            boot_sync  <= 2'b11;
            page_sync  <= 2'b11;
            boot_prev  <= 1'b1;
            page_prev  <= 1'b1;
            sel_boot   <= 1'b0;
            word_count <= '0;
            word_total <= '0;
            byte_reg   <= '0;
            word_k     <= '0;
            wr_phase   <= '0;
        end else begin
            boot_sync <= {boot_sync[0], load_bootloader};
            page_sync <= {page_sync[0], load_page};
            boot_prev <= boot_sync[1];
            page_prev <= page_sync[1];
            if (accept) begin
                sel_boot   <= boot_fall;
                word_count <= '0;
                word_total <= boot_fall ? BUF_ADDR_W'(BOOT_WORDS) : BUF_ADDR_W'(PAGE_WORDS);
                word_k     <= '0;
                wr_phase   <= '0;
            end
            if (state == ST_DATA && byte_valid) begin
                byte_reg <= rx_byte;
                word_k   <= '0;
                wr_phase <= '0;
            end
            if (state == ST_WRITE) begin
                if (wr_phase == 2'd2) begin
                    wr_phase   <= '0;
                    word_k     <= word_k + 1'b1;
                    word_count <= word_count + 1'b1;
                end else begin
                    wr_phase <= wr_phase + 1'b1;
                end
            end
        end
    end

    assign bubble_buffer_write_address    = word_count;
    assign bubble_buffer_write_data_input = word_of_byte(byte_reg, word_k);
    assign loader_state                   = state;

endmodule

// File: tb/tb_bubble_flash_loader.sv
// Bench for bubble_flash_loader: SPI flash model, buffer-write scoreboard and
// directed request scenarios (page, bootloader, collision, abort, reset, re-request).
module tb_bubble_flash_loader;

    logic        master_clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_bootloader = 1'b1;
    logic        load_page = 1'b1;
    logic [11:0] page_number = '0;
    logic        spi_miso = 1'b0;
    logic        spi_cs_n, spi_sck, spi_mosi;
    logic [10:0] wr_addr;
    logic [1:0]  wr_data;
    logic        wr_en_n, wr_clk;
    logic        loader_busy, loader_done;
    logic [2:0]  loader_state;

    bubble_flash_loader dut (
        .master_clock                   (master_clock),
        .reset                          (reset),
        .load_bootloader                (load_bootloader),
        .load_page                      (load_page),
        .page_number                    (page_number),
        .spi_cs_n                       (spi_cs_n),
        .spi_sck                        (spi_sck),
        .spi_mosi                       (spi_mosi),
        .spi_miso                       (spi_miso),
        .bubble_buffer_write_address    (wr_addr),
        .bubble_buffer_write_data_input (wr_data),
        .bubble_buffer_write_enable     (wr_en_n),
        .bubble_buffer_write_clock      (wr_clk),
        .loader_busy                    (loader_busy),
        .loader_done                    (loader_done),
        .loader_state                   (loader_state)
    );

    // ---------------- clock ----------------
    always #10 master_clock = ~master_clock;

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (a == 24'h000380) return 8'he4;
        return (a[7:0] * 8'd13) ^ a[15:8] ^ 8'h5a;
    endfunction

    // ---------------- scoreboard ----------------
    logic [12:0] exp_q[$];
    int          wr_count = 0;
    logic [10:0] last_addr = '0;
    logic        wr_clk_prev = 1'b0;

    task automatic push_load(input logic [23:0] base, input int words);
        logic [7:0] b;
        logic [1:0] d;
        for (int i = 0; i < words; i++) begin
            b = flash_byte(base + 24'(i / 4));
            d = 2'(b >> (6 - 2 * (i % 4)));
            exp_q.push_back({11'(i), d});
        end
    endtask

    always @(negedge master_clock) begin
        logic [12:0] e;
        if (wr_clk && !wr_clk_prev) begin
            check("wr_enable_low", 32'(wr_en_n), 32'd0);
            if (exp_q.size() == 0) begin
                check("wr_unexpected_q_size", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(e));
            end
            last_addr = wr_addr;
            wr_count++;
        end
        wr_clk_prev = wr_clk;
    end

    // ---------------- SPI flash model (mode 0) ----------------
    logic [31:0] fl_cmd = '0;
    logic [31:0] fl_last_cmd = '0;
    logic        fl_cmd_seen = 1'b0;
    logic [23:0] fl_addr = '0;
    logic [7:0]  fl_byte;
    logic        sck_prev = 1'b0;
    int          fl_bits = 0;
    int          fl_out = 0;

    always @(negedge master_clock) begin
        if (spi_cs_n) begin
            fl_bits = 0;
            fl_out  = 0;
        end else begin
            if (spi_sck && !sck_prev) begin
                if (fl_bits < 32) begin
                    fl_cmd = {fl_cmd[30:0], spi_mosi};
                    if (fl_bits == 31) begin
                        fl_addr     = fl_cmd[23:0];
                        fl_last_cmd = fl_cmd;
                        fl_cmd_seen = 1'b1;
                    end
                end
                fl_bits++;
            end
            if (!spi_sck && sck_prev && fl_bits >= 32) begin
                fl_byte  = flash_byte(fl_addr);
                spi_miso = fl_byte[7 - fl_out];
                fl_out++;
                if (fl_out == 8) begin
                    fl_out  = 0;
                    fl_addr = fl_addr + 24'd1;
                end
            end
        end
        sck_prev = spi_sck;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge master_clock);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while (!loader_done && c < budget) begin
            @(negedge master_clock);
            c++;
        end
        check({tag, "_done"}, 32'(loader_done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(loader_busy), 32'd0);
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int c = 0;
        while (wr_count < target && c < budget) begin
            @(negedge master_clock);
            c++;
        end
        check({tag, "_reached"}, 32'(wr_count >= target), 32'd1);
    endtask

    task automatic wait_cmd(input string tag, input logic [31:0] exp_cmd, input int budget);
        int c = 0;
        while (!fl_cmd_seen && c < budget) begin
            @(negedge master_clock);
            c++;
        end
        check({tag, "_cmd_seen"}, 32'(fl_cmd_seen), 32'd1);
        check({tag, "_cmd"}, fl_last_cmd, exp_cmd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;

        tick(3);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sck_mosi", 32'({spi_sck, spi_mosi}), 32'd0);
        check("rst_we_wclk", 32'({wr_en_n, wr_clk}), 32'b10);
        check("rst_addr_data", 32'({wr_addr, wr_data}), 32'd0);
        check("rst_busy_done", 32'({loader_busy, loader_done}), 32'd0);
        check("rst_state", 32'(loader_state), 32'd0);
        reset = 1'b0;
        tick(2);

        // page 3 load, busy latency
        page_number = 12'd3;
        push_load(24'h000380, 512);
        fl_cmd_seen = 1'b0;
        base = wr_count;
        load_page = 1'b0;
        tick(2);
        check("busy_before_accept", 32'(loader_busy), 32'd0);
        tick(1);
        check("busy_rise", 32'(loader_busy), 32'd1);
        wait_cmd("page3", 32'h03000380, 400);
        wait_done("page3", 8000);
        check("page3_count", 32'(wr_count - base), 32'd512);
        check("page3_q_empty", 32'(exp_q.size()), 32'd0);
        load_page = 1'b1;
        tick(4);
        check("page3_done_clear", 32'(loader_done), 32'd0);

        // bootloader load
        push_load(24'h000000, 1920);
        fl_cmd_seen = 1'b0;
        base = wr_count;
        load_bootloader = 1'b0;
        wait_cmd("boot", 32'h03000000, 400);
        wait_done("boot", 25000);
        check("boot_count", 32'(wr_count - base), 32'd1920);
        check("boot_last_addr", 32'(last_addr), 32'd1919);
        check("boot_q_empty", 32'(exp_q.size()), 32'd0);
        load_bootloader = 1'b1;
        tick(2);
        check("boot_done_hold", 32'(loader_done), 32'd1);
        tick(1);
        check("boot_done_clear", 32'(loader_done), 32'd0);
        tick(4);

        // simultaneous requests: bootloader wins, page edge dropped
        page_number = 12'd5;
        fl_cmd_seen = 1'b0;
        base = wr_count;
        load_bootloader = 1'b0;
        load_page = 1'b0;
        wait_cmd("simul", 32'h03000000, 400);
        load_bootloader = 1'b1;
        load_page = 1'b1;
        tick(3);
        check("simul_abort_cs", 32'(spi_cs_n), 32'd1);
        tick(300);
        check("simul_no_writes", 32'(wr_count - base), 32'd0);
        check("simul_idle_cs", 32'(spi_cs_n), 32'd1);
        check("simul_done", 32'(loader_done), 32'd0);

        // page abort after 100 writes
        page_number = 12'd7;
        push_load(24'h000580, 512);
        base = wr_count;
        load_page = 1'b0;
        wait_writes("abort", base + 100, 3000);
        load_page = 1'b1;
        tick(3);
        check("abort_cs", 32'(spi_cs_n), 32'd1);
        check("abort_busy", 32'(loader_busy), 32'd0);
        tick(200);
        check("abort_count", 32'(wr_count - base), 32'd100);
        check("abort_done", 32'(loader_done), 32'd0);
        exp_q.delete();

        // reset in the middle of the first data byte
        page_number = 12'd1;
        load_page = 1'b0;
        for (int c = 0; c < 400 && fl_bits < 36; c++) tick(1);
        check("reset_in_data", 32'(fl_bits >= 36), 32'd1);
        reset = 1'b1;
        load_page = 1'b1;
        tick(1);
        check("midrst_cs_sck", 32'({spi_cs_n, spi_sck}), 32'b10);
        check("midrst_we_busy", 32'({wr_en_n, loader_busy}), 32'b10);
        tick(2);
        reset = 1'b0;
        tick(3);

        // fresh page load from address 0, with a stray bootloader edge while busy
        page_number = 12'd2;
        push_load(24'h000300, 512);
        fl_cmd_seen = 1'b0;
        base = wr_count;
        load_page = 1'b0;
        wait_cmd("page2", 32'h03000300, 400);
        wait_writes("page2_mid", base + 200, 4000);
        load_bootloader = 1'b0;
        tick(6);
        load_bootloader = 1'b1;
        wait_done("page2", 8000);
        check("page2_count", 32'(wr_count - base), 32'd512);
        check("page2_q_empty", 32'(exp_q.size()), 32'd0);
        load_page = 1'b1;
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
